// File: rtl/yarp_fetch_unit.sv
// YARP instruction fetch stage: owns the PC, fetches over req/gnt/rvalid and
// hands each instruction to decode over valid/ready, honouring execute redirects.
module yarp_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch_taken_i,
  input  logic        is_jump_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misaligned_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, HOLD, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        kill_q, kill_d;
  logic        misaligned_q, misaligned_d;
  logic        redirect;
  logic        bad_target;

  assign redirect   = branch_taken_i | is_jump_i;
  assign bad_target = ALIGN_CHECK && (redirect_pc_i[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      instr_pc_q   <= 32'h0;
      kill_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      kill_q       <= kill_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    kill_d       = kill_q;
    misaligned_d = misaligned_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = redirect_pc_i;
      end
      REQ: begin
        if (redirect) pc_d = redirect_pc_i;
        // A request granted alongside a redirect is wrong-path but must still drain.
        if (imem_gnt_i) begin
          state_d = WAIT_RSP;
          kill_d  = redirect;
        end
      end
      WAIT_RSP: begin
        if (imem_rvalid_i) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = REQ;
            if (redirect) pc_d = redirect_pc_i;
          end else begin
            instr_d    = imem_rdata_i;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = redirect_pc_i;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc_i;
          state_d = REQ;
        end else if (instr_ready_i) begin
          state_d = REQ;
        end
      end
      FAULT: ;
      default: state_d = IDLE;
    endcase

    // A misaligned target overrides everything above and leaves the PC untouched.
    if (state_q != FAULT && redirect && bad_target) begin
      state_d      = FAULT;
      misaligned_d = 1'b1;
      pc_d         = pc_q;
      kill_d       = 1'b0;
      instr_d      = instr_q;
      instr_pc_d   = instr_pc_q;
    end
  end

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == HOLD);
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign misaligned_o  = misaligned_q;

endmodule
